// File: rtl/dcache_pkg.sv
// Shared types and constants for the parametrised L1 data cache.
package dcache_pkg;

  localparam int unsigned LINE_BITS      = 256;
  localparam int unsigned OFFSET_BITS    = 5;
  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {
    IDLE_COMPARE,
    WRITEBACK,
    FILL
  } dcache_state_t;

  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  byte_en);
    logic [31:0] merged;
    for (int unsigned b = 0; b < 4; b++) begin
      merged[8*b +: 8] = byte_en[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/param_dcache_plru_tree.sv
// Tree pseudo-LRU: victim selection and post-access tree update for one set.
module plru_tree
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int unsigned TREE_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
  input  logic [TREE_W-1:0] tree_bits,
  input  logic [WAY_W-1:0]  access_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic [TREE_W-1:0] next_bits
);

  if (NUM_WAYS == 1) begin : g_single
    logic unused_in;
    assign unused_in  = ^{tree_bits, access_way};
    assign victim_way = '0;
    assign next_bits  = '0;
  end else begin : g_tree
    // Heap-ordered nodes; tree level l is steered by way bit l (LSB first).
    always_comb begin
      int unsigned node;
      victim_way = '0;
      next_bits  = tree_bits;
      node       = 1;
      for (int unsigned l = 0; l < WAY_W; l++) begin
        victim_way[l] = tree_bits[node-1];
        node = 2 * node + (victim_way[l] ? 1 : 0);
      end
      node = 1;
      for (int unsigned l = 0; l < WAY_W; l++) begin
        next_bits[node-1] = ~access_way[l];
        node = 2 * node + (access_way[l] ? 1 : 0);
      end
    end
  end

endmodule

// File: rtl/param_dcache.sv
// Set-associative write-back/write-allocate L1 data cache with tree-PLRU replacement.
module param_dcache
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic                 stall_cache,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = 32 - OFFSET_BITS - IDX_W;
  localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned TREE_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  dcache_state_t        state;
  logic [NUM_WAYS-1:0]  valid [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty [NUM_SETS];
  logic [TREE_W-1:0]    plru  [NUM_SETS];
  logic [TAG_W-1:0]     tags  [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] lines [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [2:0]           wsel;
  logic                 req, is_write, hit, inv_found, unused_addr;
  logic [WAY_W-1:0]     hit_way, plru_victim, victim, victim_q;
  logic [TREE_W-1:0]    plru_next;
  logic [31:0]          hit_word;
  logic [LINE_BITS-1:0] merged_line;

  assign idx         = mem_address[OFFSET_BITS +: IDX_W];
  assign tag         = mem_address[31 -: TAG_W];
  assign wsel        = mem_address[4:2];
  assign unused_addr = ^mem_address[1:0];
  assign req         = mem_read | mem_write;
  assign is_write    = mem_write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid[idx][w] && (tags[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins; PLRU only decides once the set is full.
  always_comb begin
    victim    = plru_victim;
    inv_found = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!inv_found && !valid[idx][w]) begin
        victim    = WAY_W'(w);
        inv_found = 1'b1;
      end
    end
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .tree_bits  (plru[idx]),
    .access_way (hit_way),
    .victim_way (plru_victim),
    .next_bits  (plru_next)
  );

  assign hit_word    = lines[idx][hit_way][{wsel, 5'b0} +: 32];
  assign mem_rdata   = hit_word;
  assign mem_resp    = (state == IDLE_COMPARE) && req && hit;
  assign stall_cache = req & ~mem_resp;
  assign pmem_wdata  = lines[idx][victim_q];

  always_comb begin
    merged_line = lines[idx][hit_way];
    merged_line[{wsel, 5'b0} +: 32] = merge_word(hit_word, mem_wdata, mem_byte_enable);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE_COMPARE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      victim_q     <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE_COMPARE: begin
          if (req && hit) begin
            plru[idx] <= plru_next;
            if (is_write) dirty[idx][hit_way] <= 1'b1;
          end else if (req) begin
            victim_q <= victim;
            if (valid[idx][victim] && dirty[idx][victim]) begin
              state        <= WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_address <= {tags[idx][victim], idx, 5'b0};
            end else begin
              state        <= FILL;
              pmem_read    <= 1'b1;
              pmem_address <= {tag, idx, 5'b0};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state        <= FILL;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {tag, idx, 5'b0};
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state                 <= IDLE_COMPARE;
            pmem_read             <= 1'b0;
            valid[idx][victim_q]  <= 1'b1;
            dirty[idx][victim_q]  <= 1'b0;
          end
        end
        default: state <= IDLE_COMPARE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (mem_resp && is_write) lines[idx][hit_way] <= merged_line;
    if ((state == FILL) && pmem_resp) begin
      lines[idx][victim_q] <= pmem_rdata;
      tags[idx][victim_q]  <= tag;
    end
  end

endmodule

// File: tb/tb_param_dcache.sv
// Randomised self-checking bench for param_dcache (4-way/8-set and 1-way/64-set builds).
module tb_param_dcache;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          n_wb, n_fill, wb_cyc, fill_cyc;
    logic [31:0] wb_addr, fill_addr;
    logic [255:0] wb_data;
    bit          both_err, align_err;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, pmem_resp;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [255:0] pmem_rdata;
  bit sel;

  logic        rd_a, wr_a, resp_a, stall_a, prd_a, pwr_a, presp_a;
  logic        rd_b, wr_b, resp_b, stall_b, prd_b, pwr_b, presp_b;
  logic [31:0] rdata_a, rdata_b, paddr_a, paddr_b;
  logic [255:0] pwdata_a, pwdata_b;

  logic        mem_resp_v, stall_v, pmem_read_v, pmem_write_v;
  logic [31:0] mem_rdata_v, pmem_address_v;
  logic [255:0] pmem_wdata_v;

  int n_tests = 0;
  int n_fail  = 0;

  bit [255:0] bmem [int unsigned];
  bit [255:0] refm [int unsigned];

  assign rd_a = mem_read & ~sel;   assign wr_a = mem_write & ~sel;  assign presp_a = pmem_resp & ~sel;
  assign rd_b = mem_read & sel;    assign wr_b = mem_write & sel;   assign presp_b = pmem_resp & sel;
  assign mem_resp_v     = sel ? resp_b   : resp_a;
  assign stall_v        = sel ? stall_b  : stall_a;
  assign pmem_read_v    = sel ? prd_b    : prd_a;
  assign pmem_write_v   = sel ? pwr_b    : pwr_a;
  assign mem_rdata_v    = sel ? rdata_b  : rdata_a;
  assign pmem_address_v = sel ? paddr_b  : paddr_a;
  assign pmem_wdata_v   = sel ? pwdata_b : pwdata_a;

  param_dcache #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_a), .mem_write(wr_a),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(rdata_a), .mem_resp(resp_a), .stall_cache(stall_a),
    .pmem_address(paddr_a), .pmem_read(prd_a), .pmem_write(pwr_a),
    .pmem_wdata(pwdata_a), .pmem_rdata(pmem_rdata), .pmem_resp(presp_a)
  );

  param_dcache #(.NUM_WAYS(1), .NUM_SETS(64)) dut_dm (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_b), .mem_write(wr_b),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(rdata_b), .mem_resp(resp_b), .stall_cache(stall_b),
    .pmem_address(paddr_b), .pmem_read(prd_b), .pmem_write(pwr_b),
    .pmem_wdata(pwdata_b), .pmem_rdata(pmem_rdata), .pmem_resp(presp_b)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model: physical memory + CPU-visible view
  function automatic logic [255:0] init_line(int unsigned la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = (la * 32'h9E3779B1) ^ (i * 32'h01010101);
    return l;
  endfunction

  function automatic logic [255:0] mem_get(int unsigned la);
    return bmem.exists(la) ? bmem[la] : init_line(la);
  endfunction

  function automatic logic [255:0] ref_get(int unsigned la);
    return refm.exists(la) ? refm[la] : mem_get(la);
  endfunction

  function automatic int unsigned line_of(logic [31:0] a);
    return {5'b0, a[31:5]};
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    logic [255:0] l;
    int w;
    l = ref_get(line_of(a));
    w = int'(a[4:2]);
    return l[32*w +: 32];
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [255:0] l;
    int w;
    l = ref_get(line_of(a));
    w = int'(a[4:2]);
    for (int b = 0; b < 4; b++) if (be[b]) l[32*w + 8*b +: 8] = wd[8*b +: 8];
    refm[line_of(a)] = l;
  endtask

  // ---------------- stimulus: one CPU access, servicing physical memory meanwhile
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, output acc_t r);
    int cyc, wait_n, delay;
    r = '{lat: -1, rdata: '0, n_wb: 0, n_fill: 0, wb_cyc: -1, fill_cyc: -1,
          wb_addr: '0, fill_addr: '0, wb_data: '0, both_err: 1'b0, align_err: 1'b0};
    delay  = int'($urandom_range(0, 3));
    wait_n = 0;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp_v) begin
        r.rdata = mem_rdata_v;
        r.lat   = cyc;
        break;
      end
      if (pmem_read_v && pmem_write_v) r.both_err = 1'b1;
      if ((pmem_read_v || pmem_write_v) && (pmem_address_v[4:0] != 5'd0)) r.align_err = 1'b1;
      if (pmem_read_v || pmem_write_v) begin
        if (wait_n >= delay) begin
          if (pmem_write_v) begin
            r.n_wb++; r.wb_addr = pmem_address_v; r.wb_data = pmem_wdata_v; r.wb_cyc = cyc;
            bmem[line_of(pmem_address_v)] = pmem_wdata_v;
          end else begin
            r.n_fill++; r.fill_addr = pmem_address_v; r.fill_cyc = cyc;
            pmem_rdata = mem_get(line_of(pmem_address_v));
          end
          pmem_resp = 1'b1;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end
    end
    if (r.lat < 0) $display("FAIL access_timeout addr=%h got no mem_resp, required one within 300 cycles", addr);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    refm.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests
  task automatic test_reset;
    sel = 1'b0; rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    mem_address = '0; mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0;
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (mem_resp_v !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_resp got %b exp 0", mem_resp_v); end
    n_tests++; if (pmem_read_v !== 1'b0)   begin n_fail++; $display("FAIL reset_pmem_read got %b exp 0", pmem_read_v); end
    n_tests++; if (pmem_write_v !== 1'b0)  begin n_fail++; $display("FAIL reset_pmem_write got %b exp 0", pmem_write_v); end
    n_tests++; if (pmem_address_v !== 32'h0) begin n_fail++; $display("FAIL reset_pmem_address got %h exp 0", pmem_address_v); end
    n_tests++; if (stall_v !== 1'b0)       begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_v); end
    do_reset();
  endtask

  task automatic test_cold_read;
    acc_t r;
    logic [255:0] l;
    logic [31:0] exp;
    do_reset();
    l = init_line(2); l[63:32] = 32'hDEADBEEF; bmem[2] = l;
    exp = ref_word(32'h40);
    access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, r);
    n_tests++; if (r.fill_addr !== 32'h40) begin n_fail++; $display("FAIL cold_fill_addr got %h exp 00000040", r.fill_addr); end
    n_tests++; if (r.n_wb !== 0 || r.n_fill !== 1) begin n_fail++; $display("FAIL cold_ops got wb=%0d fill=%0d exp wb=0 fill=1", r.n_wb, r.n_fill); end
    n_tests++; if (r.lat !== r.fill_cyc + 1) begin n_fail++; $display("FAIL cold_latency got %0d exp %0d", r.lat, r.fill_cyc + 1); end
    n_tests++; if (r.rdata !== exp) begin n_fail++; $display("FAIL cold_rdata got %h exp %h", r.rdata, exp); end
    access(1'b1, 1'b0, 32'h44, 4'hF, 32'h0, r);
    n_tests++; if (r.lat !== 0) begin n_fail++; $display("FAIL hit_latency got %0d exp 0", r.lat); end
    n_tests++; if (r.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_rdata got %h exp deadbeef", r.rdata); end
  endtask

  task automatic test_write_merge;
    acc_t r;
    logic [31:0] a;
    access(1'b0, 1'b1, 32'h44, 4'b0101, 32'h11223344, r);
    ref_write(32'h44, 4'b0101, 32'h11223344);
    n_tests++; if (r.lat !== 0) begin n_fail++; $display("FAIL wr_hit_latency got %0d exp 0", r.lat); end
    n_tests++; if (r.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_premerge_rdata got %h exp deadbeef", r.rdata); end
    access(1'b1, 1'b0, 32'h44, 4'hF, 32'h0, r);
    n_tests++; if (r.rdata !== 32'hDE22BE44) begin n_fail++; $display("FAIL merged_rdata got %h exp de22be44", r.rdata); end
    for (int t = 1; t <= 3; t++) begin
      a = 32'h40 + 32'(t) * 32'h100;
      access(1'b1, 1'b0, a, 4'hF, 32'h0, r);
      n_tests++; if (r.n_wb !== 0 || r.rdata !== ref_word(a)) begin n_fail++; $display("FAIL conflict_fill_%0d got wb=%0d data=%h exp wb=0 data=%h", t, r.n_wb, r.rdata, ref_word(a)); end
    end
    access(1'b1, 1'b0, 32'h440, 4'hF, 32'h0, r);
    n_tests++; if (r.n_wb !== 1 || r.wb_addr !== 32'h40) begin n_fail++; $display("FAIL dirty_evict got wb=%0d addr=%h exp wb=1 addr=00000040", r.n_wb, r.wb_addr); end
    n_tests++; if (r.wb_data[63:32] !== 32'hDE22BE44) begin n_fail++; $display("FAIL dirty_evict_data got %h exp de22be44", r.wb_data[63:32]); end
    n_tests++; if (!(r.wb_cyc < r.fill_cyc) || r.fill_addr !== 32'h440) begin n_fail++; $display("FAIL wb_then_fill got wb_cyc=%0d fill_cyc=%0d fill_addr=%h exp wb first, fill 00000440", r.wb_cyc, r.fill_cyc, r.fill_addr); end
    access(1'b1, 1'b0, 32'h44, 4'hF, 32'h0, r);
    n_tests++; if (r.n_fill !== 1 || r.rdata !== 32'hDE22BE44) begin n_fail++; $display("FAIL refetch_written got fill=%0d data=%h exp fill=1 data=de22be44", r.n_fill, r.rdata); end
  endtask

  task automatic test_plru;
    acc_t r;
    logic [31:0] a, wd, exp;
    logic [3:0] be;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      a  = (32'(t) << 8) | 32'h4;
      wd = $urandom;
      be = (t == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
      exp = ref_word(a);
      access(1'b0, 1'b1, a, be, wd, r);
      ref_write(a, be, wd);
      n_tests++; if (r.n_fill !== 1 || r.n_wb !== 0 || r.rdata !== exp) begin n_fail++; $display("FAIL plru_fill_%0d got fill=%0d wb=%0d data=%h exp fill=1 wb=0 data=%h", t, r.n_fill, r.n_wb, r.rdata, exp); end
    end
    access(1'b1, 1'b0, 32'h4, 4'hF, 32'h0, r);
    n_tests++; if (r.lat !== 0 || r.rdata !== ref_word(32'h4)) begin n_fail++; $display("FAIL plru_retouch got lat=%0d data=%h exp lat=0 data=%h", r.lat, r.rdata, ref_word(32'h4)); end
    exp = ref_word(32'h400);
    access(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, r);
    n_tests++; if (r.n_wb !== 1 || r.wb_addr !== 32'h100) begin n_fail++; $display("FAIL plru_victim got wb=%0d addr=%h exp wb=1 addr=00000100", r.n_wb, r.wb_addr); end
    n_tests++; if (r.wb_data !== ref_get(8)) begin n_fail++; $display("FAIL plru_wb_data got %h exp %h", r.wb_data, ref_get(8)); end
    n_tests++; if (!(r.wb_cyc < r.fill_cyc) || r.fill_addr !== 32'h400 || r.rdata !== exp) begin n_fail++; $display("FAIL plru_fill got wb_cyc=%0d fill_cyc=%0d addr=%h data=%h exp data=%h", r.wb_cyc, r.fill_cyc, r.fill_addr, r.rdata, exp); end
    n_tests++; if (r.lat !== r.fill_cyc + 1) begin n_fail++; $display("FAIL dirty_miss_latency got %0d exp %0d", r.lat, r.fill_cyc + 1); end
    for (int t = 0; t < 4; t++) begin
      if (t == 1) continue;
      a = 32'(t) << 8;
      access(1'b1, 1'b0, a, 4'hF, 32'h0, r);
      n_tests++; if (r.lat !== 0 || r.rdata !== ref_word(a)) begin n_fail++; $display("FAIL plru_survivor_%0d got lat=%0d data=%h exp lat=0 data=%h", t, r.lat, r.rdata, ref_word(a)); end
    end
    access(1'b1, 1'b0, 32'h104, 4'hF, 32'h0, r);
    n_tests++; if (r.n_fill !== 1 || r.rdata !== ref_word(32'h104)) begin n_fail++; $display("FAIL plru_evicted_refetch got fill=%0d data=%h exp fill=1 data=%h", r.n_fill, r.rdata, ref_word(32'h104)); end
  endtask

  task automatic test_rw_together;
    acc_t r;
    logic [31:0] old, wd;
    access(1'b1, 1'b0, 32'h1C8, 4'hF, 32'h0, r);
    old = ref_word(32'h1C8);
    wd  = $urandom;
    access(1'b1, 1'b1, 32'h1C8, 4'b1100, wd, r);
    ref_write(32'h1C8, 4'b1100, wd);
    n_tests++; if (r.lat !== 0 || r.rdata !== old) begin n_fail++; $display("FAIL rw_together got lat=%0d data=%h exp lat=0 data=%h", r.lat, r.rdata, old); end
    @(negedge clk);
    n_tests++; if (mem_resp_v !== 1'b0) begin n_fail++; $display("FAIL rw_single_pulse got resp=%b exp 0", mem_resp_v); end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h1C8, 4'hF, 32'h0, r);
    n_tests++; if (r.rdata !== ref_word(32'h1C8)) begin n_fail++; $display("FAIL rw_readback got %h exp %h", r.rdata, ref_word(32'h1C8)); end
  endtask

  task automatic test_reset_mid_fill;
    acc_t r;
    bit seen;
    logic [31:0] exp;
    do_reset();
    access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, r);
    mem_read = 1'b1; mem_address = 32'h60; seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = pmem_read_v;
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midfill_request got pmem_read=%b exp 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (pmem_read_v !== 1'b0 || pmem_address_v !== 32'h0) begin n_fail++; $display("FAIL midfill_reset got pmem_read=%b addr=%h exp 0/00000000", pmem_read_v, pmem_address_v); end
    mem_read = 1'b0;
    refm.delete();
    @(negedge clk);
    rst_n = 1'b1; pmem_resp = 1'b1; pmem_rdata = '1;
    @(negedge clk);
    pmem_resp = 1'b0;
    n_tests++; if (pmem_read_v !== 1'b0 || pmem_write_v !== 1'b0 || mem_resp_v !== 1'b0) begin n_fail++; $display("FAIL stale_pmem_resp got rd=%b wr=%b resp=%b exp 0/0/0", pmem_read_v, pmem_write_v, mem_resp_v); end
    @(posedge clk); #1;
    exp = ref_word(32'h40);
    access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, r);
    n_tests++; if (r.n_fill !== 1 || r.rdata !== exp) begin n_fail++; $display("FAIL post_reset_miss got fill=%0d data=%h exp fill=1 data=%h", r.n_fill, r.rdata, exp); end
  endtask

  task automatic test_random;
    acc_t r;
    logic [31:0] a, wd, exp;
    logic [3:0] be;
    bit rd, wr;
    int kind;
    for (int i = 0; i < 200; i++) begin
      a    = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
      kind = int'($urandom_range(0, 2));
      rd   = (kind != 1);
      wr   = (kind != 0);
      be   = 4'($urandom);
      wd   = $urandom;
      exp  = ref_word(a);
      access(rd, wr, a, be, wd, r);
      n_tests++; if (r.rdata !== exp || r.lat < 0) begin n_fail++; $display("FAIL rand_rdata[%0d] addr=%h got %h exp %h", i, a, r.rdata, exp); end
      if (r.n_wb > 0) begin
        n_tests++; if (r.wb_data !== ref_get(line_of(r.wb_addr))) begin n_fail++; $display("FAIL rand_wb_data[%0d] addr=%h got %h exp %h", i, r.wb_addr, r.wb_data, ref_get(line_of(r.wb_addr))); end
      end
      n_tests++; if (r.both_err || r.align_err) begin n_fail++; $display("FAIL rand_pmem_protocol[%0d] got both=%b misaligned=%b exp 0/0", i, r.both_err, r.align_err); end
      if (wr) ref_write(a, be, wd);
    end
  endtask

  task automatic test_direct_mapped;
    acc_t r;
    logic [31:0] a, wd, exp;
    bit wr, res_valid, res_dirty;
    int unsigned res_la;
    sel = 1'b1;
    do_reset();
    res_valid = 1'b0; res_dirty = 1'b0; res_la = 0;
    for (int i = 0; i < 8; i++) begin
      a   = ((i % 2) == 1) ? 32'h804 : 32'h4;
      wr  = (i % 4) < 2;
      wd  = $urandom;
      exp = ref_word(a);
      access(~wr, wr, a, 4'hF, wd, r);
      n_tests++; if (r.n_fill !== 1 || r.lat !== r.fill_cyc + 1 || r.rdata !== exp) begin n_fail++; $display("FAIL dm_miss[%0d] got fill=%0d lat=%0d data=%h exp fill=1 lat=%0d data=%h", i, r.n_fill, r.lat, r.rdata, r.fill_cyc + 1, exp); end
      n_tests++; if (r.n_wb !== ((res_valid && res_dirty) ? 1 : 0)) begin n_fail++; $display("FAIL dm_wb_count[%0d] got %0d exp %0d", i, r.n_wb, (res_valid && res_dirty) ? 1 : 0); end
      if (res_valid && res_dirty) begin
        n_tests++; if (r.wb_addr !== {res_la[26:0], 5'b0} || r.wb_data !== ref_get(res_la)) begin n_fail++; $display("FAIL dm_wb[%0d] got addr=%h exp addr=%h", i, r.wb_addr, {res_la[26:0], 5'b0}); end
      end
      if (wr) ref_write(a, 4'hF, wd);
      res_valid = 1'b1; res_la = line_of(a); res_dirty = wr;
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_merge();
    test_plru();
    test_rw_together();
    test_reset_mid_fill();
    test_random();
    test_direct_mapped();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
